kbbuf_fifo: RTL and testbench

KBBUF_FIFO -- requirements
Module: kbbuf_fifo

---
 rtl/kbbuf_pkg.sv | 12 +
 rtl/kbbuf_ram.sv | 26 ++
 rtl/kbbuf_fifo.sv | 120 ++++++++++++
 tb/tb_kbbuf_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/kbbuf_pkg.sv
// Shared constants for the keyboard byte FIFO: the status bit positions and the default depth.
package kbbuf_pkg;

  localparam int DEPTH_LOG2_DEF = 4;

  localparam int STAT_NOTEMPTY = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVF      = 2;

  localparam int DATA_W = 8;

endpackage : kbbuf_pkg

// File: rtl/kbbuf_ram.sv
// Keyboard FIFO storage: one synchronous write port and one asynchronous read port.
// The array has no reset because an empty FIFO never exposes its contents.
module kbbuf_ram
  import kbbuf_pkg::*;
#(
  parameter int ADDR_W = DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : kbbuf_ram

// File: rtl/kbbuf_fifo.sv
// Keyboard byte FIFO between the SPI register block and the CPU data port.
// Build option: define KBBUF_IRQ_EN to add the registered irq output.
module kbbuf_fifo
  import kbbuf_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_en,
  input  logic                  rd_pop,
  input  logic                  clr,
  input  logic                  ovf_clr,
  output logic [DATA_W-1:0]     rd_data,
  output logic [7:0]            status,
  output logic [DEPTH_LOG2:0]   count
`ifdef KBBUF_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam logic [DEPTH_LOG2:0]   L_CNT_FULL = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   L_CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] L_PTR_ONE  = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovf;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_do_wr;
  logic                  w_do_rd;
  logic                  w_ovf_set;
  logic                  w_ram_we;
  logic [DATA_W-1:0]     w_ram_rdata;

  // Strobe semantics: wr_en, rd_pop, clr and ovf_clr are one-cycle pulses sampled on
  // the rising edge; there is no back-pressure, so a write offered to a full FIFO
  // without a same-cycle pop is dropped and recorded in the sticky overflow flag.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == L_CNT_FULL);
  assign w_do_rd   = rd_pop && !w_empty;
  assign w_do_wr   = wr_en && (!w_full || rd_pop);
  assign w_ovf_set = wr_en && w_full && !rd_pop;
  assign w_ram_we  = w_do_wr && !clr;

  // When full, a simultaneous write lands on the slot the pop is vacating.
  kbbuf_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_wptr),
    .i_wdata (wr_data),
    .i_raddr (r_rptr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_do_wr) begin
        r_wptr <= r_wptr + L_PTR_ONE;
      end
      if (w_do_rd) begin
        r_rptr <= r_rptr + L_PTR_ONE;
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + L_CNT_ONE;
        2'b01:   r_count <= r_count - L_CNT_ONE;
        default: r_count <= r_count;
      endcase
      // A set in the same cycle as ovf_clr wins.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    status                = 8'h00;
    status[STAT_NOTEMPTY] = !w_empty;
    status[STAT_FULL]     = w_full;
    status[STAT_OVF]      = r_ovf;
  end

  assign count   = r_count;
  assign rd_data = w_empty ? '0 : w_ram_rdata;

`ifdef KBBUF_IRQ_EN
  // Follows occupancy one cycle late, so a flush drops it on the following edge.
  logic r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= !w_empty;
    end
  end

  assign irq = r_irq;
`endif

endmodule : kbbuf_fifo

// File: tb/tb_kbbuf_fifo.sv
// Directed bench for kbbuf_fifo; expected values are hand-derived and checked by assertions.
module tb_kbbuf_fifo;

  localparam int DL2 = 4;

  logic           clk;
  logic           reset_n;
  logic [7:0]     wr_data;
  logic           wr_en;
  logic           rd_pop;
  logic           clr;
  logic           ovf_clr;
  logic [7:0]     rd_data;
  logic [7:0]     status;
  logic [DL2:0]   count;
`ifdef KBBUF_IRQ_EN
  logic           irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  kbbuf_fifo #(
    .DEPTH_LOG2 (DL2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_pop  (rd_pop),
    .clr     (clr),
    .ovf_clr (ovf_clr),
    .rd_data (rd_data),
    .status  (status),
    .count   (count)
`ifdef KBBUF_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: present one cycle of strobes, sample #1 after the edge, then idle them.
  task automatic cyc(input logic w, input logic [7:0] d, input logic p,
                     input logic c, input logic oc);
    wr_en   = w;
    wr_data = d;
    rd_pop  = p;
    clr     = c;
    ovf_clr = oc;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_pop  = 1'b0;
    clr     = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    wr_data = 8'h00;
    wr_en   = 1'b0;
    rd_pop  = 1'b0;
    clr     = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_data", 16'(rd_data), 16'h00);
    chk("reset_status", 16'(status), 16'h00);
    chk("reset_count", 16'(count), 16'd0);
`ifdef KBBUF_IRQ_EN
    chk("reset_irq", 16'(irq), 16'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Pop on empty is ignored with no flag
    pop();
    chk("empty_pop_count", 16'(count), 16'd0);
    chk("empty_pop_status", 16'(status), 16'h00);

    // Two writes, one pop
    wr(8'h41);
    chk("w1_rd_data", 16'(rd_data), 16'h41);
    chk("w1_count", 16'(count), 16'd1);
    chk("w1_status", 16'(status), 16'h01);
`ifdef KBBUF_IRQ_EN
    chk("w1_irq_not_yet", 16'(irq), 16'd0);
`endif
    wr(8'h42);
    chk("w2_rd_data", 16'(rd_data), 16'h41);
    chk("w2_count", 16'(count), 16'd2);
`ifdef KBBUF_IRQ_EN
    chk("w2_irq", 16'(irq), 16'd1);
`endif
    pop();
    chk("p1_rd_data", 16'(rd_data), 16'h42);
    chk("p1_count", 16'(count), 16'd1);
    chk("p1_status", 16'(status), 16'h01);
    pop();
    chk("p2_count", 16'(count), 16'd0);
    chk("p2_rd_data", 16'(rd_data), 16'h00);

    // Fill, overflow, drain in order
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("fill_count", 16'(count), 16'd16);
    chk("fill_status", 16'(status), 16'h03);
    wr(8'hFF);
    chk("ovf_status", 16'(status), 16'h07);
    chk("ovf_count", 16'(count), 16'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 16'(rd_data), 16'(i));
      pop();
    end
    chk("drain_count", 16'(count), 16'd0);
    chk("drain_status", 16'(status), 16'h04);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr_status", 16'(status), 16'h00);

    // Full with simultaneous write and pop
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i));
    cyc(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    chk("full_wp_count", 16'(count), 16'd16);
    chk("full_wp_status", 16'(status), 16'h03);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("ovf_set_wins", 16'(status), 16'h07);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr_full", 16'(status), 16'h03);
    for (int i = 1; i < 16; i++) begin
      chk("full_wp_data", 16'(rd_data), 16'(8'h10 + i));
      pop();
    end
    chk("full_wp_last", 16'(rd_data), 16'hAA);
    pop();
    chk("full_wp_empty", 16'(count), 16'd0);

    // Empty with simultaneous write and pop, then wrap with a scoreboard
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("empty_wp_count", 16'(count), 16'd1);
    chk("empty_wp_data", 16'(rd_data), 16'h55);
    exp_q.push_back(8'h55);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      chk("wrap_data", 16'(rd_data), 16'(exp_q.pop_front()));
      exp_q.push_back(d);
      cyc(1'b1, d, 1'b1, 1'b0, 1'b0);
      chk("wrap_count", 16'(count), 16'd1);
    end
    chk("wrap_final", 16'(rd_data), 16'(exp_q.pop_front()));
    pop();
    chk("wrap_empty", 16'(count), 16'd0);

    // Count 5 with overflow, then clr wins over a write
    for (int i = 0; i < 17; i++) wr(8'(8'h80 + i));
    for (int i = 0; i < 11; i++) pop();
    chk("pre_clr_count", 16'(count), 16'd5);
    chk("pre_clr_status", 16'(status), 16'h05);
    cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    chk("clr_count", 16'(count), 16'd0);
    chk("clr_status", 16'(status), 16'h00);
    chk("clr_rd_data", 16'(rd_data), 16'h00);
`ifdef KBBUF_IRQ_EN
    chk("clr_irq_held", 16'(irq), 16'd1);
`endif
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef KBBUF_IRQ_EN
    chk("clr_irq_fall", 16'(irq), 16'd0);
`endif
    wr(8'h77);
    chk("post_clr_data", 16'(rd_data), 16'h77);
    pop();

    // Reset mid-burst
    for (int i = 0; i < 9; i++) wr(8'(8'hC0 + i));
    chk("burst_count", 16'(count), 16'd9);
    reset_n = 1'b0;
    #1;
    chk("rst_rd_data", 16'(rd_data), 16'h00);
    chk("rst_status", 16'(status), 16'h00);
    chk("rst_count", 16'(count), 16'd0);
`ifdef KBBUF_IRQ_EN
    chk("rst_irq", 16'(irq), 16'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    wr(8'h31);
    chk("post_rst_data", 16'(rd_data), 16'h31);
    chk("post_rst_count", 16'(count), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_kbbuf_fifo
